// File: rtl/art_fault_ctl.sv
// art_fault_ctl: fault-side responder for the I-side and D-side ART FSMs.
//
// Each side has a one-deep capture stage that latches a miss/permission fault pulse together
// with its address and access type. A three-state controller (Idle/Report/AckOut) serialises
// the captured faults to the CPU as a level exception with cause, side and address
// registers. When the CPU clears the exception, a single-cycle ack is returned to the side
// that was served.
//
// Ports:
//   Clk, Reset                          clock, synchronous active-high reset
//   i_I_Miss_Fault/i_I_Perm_Fault       I-side fault pulses, i_I_Adr is the faulting address
//   i_I_Fault_Strobe, o_I_Fault_Ack     I-side FSM echo and ack
//   i_D_Miss_Fault/i_D_Perm_Fault       D-side fault pulses, i_D_Adr / i_D_wr_op access info
//   i_D_Fault_Strobe, o_D_Fault_Ack     D-side FSM echo and ack
//   o_Exception                         level exception to the CPU
//   o_Fault_Cause                       bit0 = perm (0 = miss), bit1 = write
//   o_Fault_Side, o_Fault_Adr           0 = I, 1 = D; faulting address
//   i_Exc_Clear                         CPU has handled the fault (one-cycle pulse)
//   o_Fault_Count, i_Cnt_Clr            saturating count of served faults and its clear
//   o_Overrun                           sticky: fault arrived while the same side was pending
//   o_Proto_Err                         sticky: an FSM strobe disagreed with our ack
module art_fault_ctl #(
    parameter int unsigned ADR_W  = 32,
    parameter int unsigned CNT_W  = 16,
    parameter bit          D_PRIO = 1'b1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             i_I_Miss_Fault,
    input  logic             i_I_Perm_Fault,
    input  logic [ADR_W-1:0] i_I_Adr,
    input  logic             i_I_Fault_Strobe,
    output logic             o_I_Fault_Ack,
    input  logic             i_D_Miss_Fault,
    input  logic             i_D_Perm_Fault,
    input  logic [ADR_W-1:0] i_D_Adr,
    input  logic             i_D_wr_op,
    input  logic             i_D_Fault_Strobe,
    output logic             o_D_Fault_Ack,
    output logic             o_Exception,
    output logic [1:0]       o_Fault_Cause,
    output logic             o_Fault_Side,
    output logic [ADR_W-1:0] o_Fault_Adr,
    input  logic             i_Exc_Clear,
    output logic [CNT_W-1:0] o_Fault_Count,
    input  logic             i_Cnt_Clr,
    output logic             o_Overrun,
    output logic             o_Proto_Err
);

    typedef enum logic [2:0] {
        StIdle   = 3'b001,
        StReport = 3'b010,
        StAckOut = 3'b100
    } state_e;

    state_e             state_q, state_d;

    // Per-side capture stage
    logic               i_pend_q, i_pend_d;
    logic [ADR_W-1:0]   i_adr_q, i_adr_d;
    logic               i_perm_q, i_perm_d;
    logic               d_pend_q, d_pend_d;
    logic [ADR_W-1:0]   d_adr_q, d_adr_d;
    logic               d_perm_q, d_perm_d;
    logic               d_wr_q, d_wr_d;

    // CPU-visible registers
    logic               exc_q, exc_d;
    logic [1:0]         cause_q, cause_d;
    logic               side_q, side_d;
    logic [ADR_W-1:0]   adr_q, adr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovr_q, ovr_d;
    logic               perr_q, perr_d;

    logic               i_evt, d_evt;
    logic               ack_i, ack_d;
    logic               sel_d;

    always_comb begin
        state_d  = state_q;
        i_pend_d = i_pend_q;
        i_adr_d  = i_adr_q;
        i_perm_d = i_perm_q;
        d_pend_d = d_pend_q;
        d_adr_d  = d_adr_q;
        d_perm_d = d_perm_q;
        d_wr_d   = d_wr_q;
        exc_d    = exc_q;
        cause_d  = cause_q;
        side_d   = side_q;
        adr_d    = adr_q;
        cnt_d    = cnt_q;
        ovr_d    = ovr_q;
        perr_d   = perr_q;
        sel_d    = 1'b0;

        i_evt = i_I_Miss_Fault | i_I_Perm_Fault;
        d_evt = i_D_Miss_Fault | i_D_Perm_Fault;

        // Acks come purely from registered state; side_q names the side being served.
        ack_i = (state_q == StAckOut) & ~side_q;
        ack_d = (state_q == StAckOut) & side_q;

        // Capture: a fault on a side that is still pending (including the one being acked
        // this cycle) is dropped and flagged as an overrun.
        if (i_evt) begin
            if (i_pend_q) begin
                ovr_d = 1'b1;
            end else begin
                i_pend_d = 1'b1;
                i_adr_d  = i_I_Adr;
                i_perm_d = i_I_Perm_Fault & ~i_I_Miss_Fault;
            end
        end
        if (d_evt) begin
            if (d_pend_q) begin
                ovr_d = 1'b1;
            end else begin
                d_pend_d = 1'b1;
                d_adr_d  = i_D_Adr;
                d_perm_d = i_D_Perm_Fault & ~i_D_Miss_Fault;
                d_wr_d   = i_D_wr_op;
            end
        end
        if (ack_i) begin
            i_pend_d = 1'b0;
        end
        if (ack_d) begin
            d_pend_d = 1'b0;
        end

        if ((i_I_Fault_Strobe != ack_i) || (i_D_Fault_Strobe != ack_d)) begin
            perr_d = 1'b1;
        end

        if (i_Cnt_Clr) begin
            cnt_d = '0;
        end else if ((state_q == StAckOut) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (i_pend_q | d_pend_q) begin
                    sel_d   = D_PRIO ? d_pend_q : ~i_pend_q;
                    side_d  = sel_d;
                    adr_d   = sel_d ? d_adr_q : i_adr_q;
                    cause_d = sel_d ? {d_wr_q, d_perm_q} : {1'b0, i_perm_q};
                    exc_d   = 1'b1;
                    state_d = StReport;
                end
            end
            StReport: begin
                if (i_Exc_Clear) begin
                    exc_d   = 1'b0;
                    state_d = StAckOut;
                end
            end
            StAckOut: begin
                state_d = StIdle;
            end
            default: begin
                exc_d   = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= StIdle;
            i_pend_q <= 1'b0;
            i_adr_q  <= '0;
            i_perm_q <= 1'b0;
            d_pend_q <= 1'b0;
            d_adr_q  <= '0;
            d_perm_q <= 1'b0;
            d_wr_q   <= 1'b0;
            exc_q    <= 1'b0;
            cause_q  <= 2'b00;
            side_q   <= 1'b0;
            adr_q    <= '0;
            cnt_q    <= '0;
            ovr_q    <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_pend_q <= i_pend_d;
            i_adr_q  <= i_adr_d;
            i_perm_q <= i_perm_d;
            d_pend_q <= d_pend_d;
            d_adr_q  <= d_adr_d;
            d_perm_q <= d_perm_d;
            d_wr_q   <= d_wr_d;
            exc_q    <= exc_d;
            cause_q  <= cause_d;
            side_q   <= side_d;
            adr_q    <= adr_d;
            cnt_q    <= cnt_d;
            ovr_q    <= ovr_d;
            perr_q   <= perr_d;
        end
    end

    assign o_I_Fault_Ack = ack_i;
    assign o_D_Fault_Ack = ack_d;
    assign o_Exception   = exc_q;
    assign o_Fault_Cause = cause_q;
    assign o_Fault_Side  = side_q;
    assign o_Fault_Adr   = adr_q;
    assign o_Fault_Count = cnt_q;
    assign o_Overrun     = ovr_q;
    assign o_Proto_Err   = perr_q;

endmodule

// File: tb/tb_art_fault_ctl.sv
// Self-checking bench for art_fault_ctl: directed scenarios plus a randomized phase, with
// every output compared each cycle against a fault-queue reference model.
module tb_art_fault_ctl;

    localparam int unsigned ADR_W   = 32;
    localparam int unsigned CNT_W   = 2;
    localparam bit          D_PRIO  = 1'b1;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic             i_I_Miss_Fault = 1'b0, i_I_Perm_Fault = 1'b0;
    logic [ADR_W-1:0] i_I_Adr = '0;
    logic             i_I_Fault_Strobe = 1'b0;
    logic             o_I_Fault_Ack;
    logic             i_D_Miss_Fault = 1'b0, i_D_Perm_Fault = 1'b0;
    logic [ADR_W-1:0] i_D_Adr = '0;
    logic             i_D_wr_op = 1'b0;
    logic             i_D_Fault_Strobe = 1'b0;
    logic             o_D_Fault_Ack;
    logic             o_Exception;
    logic [1:0]       o_Fault_Cause;
    logic             o_Fault_Side;
    logic [ADR_W-1:0] o_Fault_Adr;
    logic             i_Exc_Clear = 1'b0;
    logic [CNT_W-1:0] o_Fault_Count;
    logic             i_Cnt_Clr = 1'b0;
    logic             o_Overrun;
    logic             o_Proto_Err;

    always #5 Clk = ~Clk;

    art_fault_ctl #(.ADR_W(ADR_W), .CNT_W(CNT_W), .D_PRIO(D_PRIO)) dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .i_I_Miss_Fault  (i_I_Miss_Fault),
        .i_I_Perm_Fault  (i_I_Perm_Fault),
        .i_I_Adr         (i_I_Adr),
        .i_I_Fault_Strobe(i_I_Fault_Strobe),
        .o_I_Fault_Ack   (o_I_Fault_Ack),
        .i_D_Miss_Fault  (i_D_Miss_Fault),
        .i_D_Perm_Fault  (i_D_Perm_Fault),
        .i_D_Adr         (i_D_Adr),
        .i_D_wr_op       (i_D_wr_op),
        .i_D_Fault_Strobe(i_D_Fault_Strobe),
        .o_D_Fault_Ack   (o_D_Fault_Ack),
        .o_Exception     (o_Exception),
        .o_Fault_Cause   (o_Fault_Cause),
        .o_Fault_Side    (o_Fault_Side),
        .o_Fault_Adr     (o_Fault_Adr),
        .i_Exc_Clear     (i_Exc_Clear),
        .o_Fault_Count   (o_Fault_Count),
        .i_Cnt_Clr       (i_Cnt_Clr),
        .o_Overrun       (o_Overrun),
        .o_Proto_Err     (o_Proto_Err)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model. Index 0 = I side, 1 = D side.
    bit          m_pend[2];
    logic [31:0] m_cap_adr[2];
    bit          m_cap_perm[2];
    bit          m_cap_wr[2];
    int          m_wait;      // 0 = free, 1 = exception up, 2 = returning ack this cycle
    bit          m_side;
    bit          m_exc;
    logic [1:0]  m_cause;
    logic [31:0] m_adr;
    int          m_cnt;
    bit          m_ovr, m_perr;
    bit          m_ack[2];

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_pend[s] = 0; m_cap_adr[s] = '0; m_cap_perm[s] = 0; m_cap_wr[s] = 0; m_ack[s] = 0;
        end
        m_wait = 0; m_side = 0; m_exc = 0; m_cause = 2'b00; m_adr = '0;
        m_cnt = 0; m_ovr = 0; m_perr = 0;
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_step();
        bit old_pend[2];
        bit evt[2], miss[2], perm[2];
        logic [31:0] adr_in[2];
        if (Reset) begin
            model_reset();
            return;
        end
        old_pend = m_pend;
        miss[0] = i_I_Miss_Fault; perm[0] = i_I_Perm_Fault; adr_in[0] = i_I_Adr;
        miss[1] = i_D_Miss_Fault; perm[1] = i_D_Perm_Fault; adr_in[1] = i_D_Adr;
        if (i_I_Fault_Strobe != m_ack[0] || i_D_Fault_Strobe != m_ack[1]) m_perr = 1;
        if (i_Cnt_Clr) m_cnt = 0;
        else if (m_ack[0] || m_ack[1]) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
        if (m_wait == 0) begin
            if (old_pend[0] || old_pend[1]) begin
                m_side  = D_PRIO ? old_pend[1] : !old_pend[0];
                m_adr   = m_cap_adr[m_side];
                m_cause = {m_cap_wr[m_side], m_cap_perm[m_side]};
                m_exc   = 1;
                m_wait  = 1;
            end
        end else if (m_wait == 1) begin
            if (i_Exc_Clear) begin
                m_exc  = 0;
                m_wait = 2;
            end
        end else begin
            m_wait = 0;
        end
        for (int s = 0; s < 2; s++) begin
            evt[s] = miss[s] | perm[s];
            if (evt[s]) begin
                if (old_pend[s]) m_ovr = 1;
                else begin
                    m_pend[s]     = 1;
                    m_cap_adr[s]  = adr_in[s];
                    m_cap_perm[s] = perm[s] & !miss[s];
                    m_cap_wr[s]   = (s == 1) ? i_D_wr_op : 1'b0;
                end
            end
            if (m_ack[s]) m_pend[s] = 0;
        end
        m_ack[0] = (m_wait == 2) && (m_side == 0);
        m_ack[1] = (m_wait == 2) && (m_side == 1);
    endtask

    task automatic check_all();
        check_val("exception", o_Exception, m_exc);
        check_val("cause", o_Fault_Cause, m_cause);
        check_val("side", o_Fault_Side, m_side);
        check_val("adr", o_Fault_Adr, m_adr);
        check_val("i_ack", o_I_Fault_Ack, m_ack[0]);
        check_val("d_ack", o_D_Fault_Ack, m_ack[1]);
        check_val("count", o_Fault_Count, m_cnt);
        check_val("overrun", o_Overrun, m_ovr);
        check_val("proto_err", o_Proto_Err, m_perr);
    endtask

    // One clock: model update at the edge, compare mid-cycle, then return pulse inputs to
    // idle with the strobes echoing the expected acks.
    task automatic tick();
        @(posedge Clk);
        model_step();
        @(negedge Clk);
        check_all();
        Reset = 0; i_Exc_Clear = 0; i_Cnt_Clr = 0;
        i_I_Miss_Fault = 0; i_I_Perm_Fault = 0;
        i_D_Miss_Fault = 0; i_D_Perm_Fault = 0; i_D_wr_op = 0;
        i_I_Fault_Strobe = m_ack[0];
        i_D_Fault_Strobe = m_ack[1];
    endtask

    task automatic do_reset();
        Reset = 1;
        tick();
    endtask

    task automatic fault(input bit side, input bit miss, input bit perm, input bit wr,
                         input logic [31:0] adr);
        if (side) begin
            i_D_Miss_Fault = miss; i_D_Perm_Fault = perm; i_D_wr_op = wr; i_D_Adr = adr;
        end else begin
            i_I_Miss_Fault = miss; i_I_Perm_Fault = perm; i_I_Adr = adr;
        end
    endtask

    // Wait for an exception, hold it two cycles, clear it, optionally clear the counter in
    // the ack cycle, then settle.
    task automatic serve(input bit clr_at_ack);
        for (int k = 0; k < 20 && !o_Exception; k++) tick();
        check_val("exc_rise", o_Exception, 1'b1);
        tick(); tick();
        i_Exc_Clear = 1;
        tick();
        if (clr_at_ack) i_Cnt_Clr = 1;
        tick();
        tick();
    endtask

    initial begin
        model_reset();
        Reset = 1;
        tick();
        do_reset();
        tick(); tick();

        // I miss: exception two cycles after the pulse
        fault(0, 1, 0, 0, 32'h0000_1000);
        tick();
        check_val("t1_exc_n1", o_Exception, 1'b0);
        tick();
        check_val("t1_exc_n2", o_Exception, 1'b1);
        check_val("t1_adr", o_Fault_Adr, 32'h0000_1000);
        serve(0);
        check_val("t1_count", o_Fault_Count, 1);

        // D perm write, then miss+perm together
        fault(1, 0, 1, 1, 32'h8000_0040);
        tick();
        serve(0);
        check_val("t2_cause", o_Fault_Cause, 2'b11);
        check_val("t2_side", o_Fault_Side, 1'b1);
        fault(1, 1, 1, 0, 32'h8000_0080);
        tick();
        serve(0);
        check_val("t2_miss_dom", o_Fault_Cause, 2'b00);

        // Simultaneous I and D
        fault(0, 1, 0, 0, 32'h0000_2000);
        fault(1, 1, 0, 1, 32'h0000_3000);
        tick();
        serve(0);
        serve(0);
        check_val("t3_i_adr", o_Fault_Adr, 32'h0000_2000);

        // Overrun on D
        fault(1, 1, 0, 0, 32'h0000_4000);
        tick();
        fault(1, 0, 1, 0, 32'h0000_5000);
        tick();
        serve(0);
        check_val("t4_ovr", o_Overrun, 1'b1);
        check_val("t4_adr", o_Fault_Adr, 32'h0000_4000);
        for (int k = 0; k < 6; k++) tick();

        // Reset while reporting
        fault(0, 0, 1, 0, 32'h0000_6000);
        tick(); tick();
        check_val("t6_exc_pre", o_Exception, 1'b1);
        do_reset();
        check_val("t6_exc_rst", o_Exception, 1'b0);
        for (int k = 0; k < 5; k++) tick();

        // Saturation, then clear coincident with an ack
        for (int n = 0; n < 5; n++) begin
            fault(0, 1, 0, 0, 32'h100 * n);
            tick();
            serve(0);
        end
        check_val("t6_sat", o_Fault_Count, CNT_MAX);
        fault(1, 1, 0, 0, 32'h0000_7000);
        tick();
        serve(1);
        check_val("t6_cnt_clr", o_Fault_Count, 0);
        check_val("t5_perr_clean", o_Proto_Err, 1'b0);

        // Randomized phase
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 7) == 0)
                fault(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, $urandom);
            if ($urandom_range(0, 7) == 0)
                fault(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $urandom);
            i_Exc_Clear = ($urandom_range(0, 3) == 0);
            i_Cnt_Clr   = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 249) == 0) Reset = 1;
            tick();
        end

        // Strobe without ack
        do_reset();
        tick();
        i_D_Fault_Strobe = 1;
        tick();
        tick();
        check_val("t5_perr", o_Proto_Err, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
